// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage (main + skid register) with flush and a saturating discard counter.
// All state updates on the falling clock edge; rst is asynchronous and active low.
module pipe_stage_reg #(
  parameter int DATA_W          = 101,
  parameter int CTRL_W          = 10,
  parameter int FLUSH_KEEP_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [15:0]       kill_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   main_data_reg;
  logic [CTRL_W-1:0]   main_ctrl_reg;
  logic [DATA_W-1:0]   skid_data_reg;
  logic [CTRL_W-1:0]   skid_ctrl_reg;
  logic [15:0]         kill_reg;

  logic                in_fire;
  logic                out_fire;
  logic [1:0]          occ;
  logic [16:0]         kill_sum;

  // Handshake outputs decode from state only, so in_ready has no path from out_ready.
  assign occ       = state_reg;
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_data  = main_data_reg;
  assign out_ctrl  = out_valid ? main_ctrl_reg : '0;
  assign occupancy = occ;
  assign kill_cnt  = kill_reg;

  assign kill_sum  = {1'b0, kill_reg} + {15'd0, occ} + {16'd0, in_fire};

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      kill_reg      <= '0;
    end else if (flush) begin
      // Everything held or arriving this cycle counts as discarded, even if it also left.
      state_reg     <= EMPTY;
      main_ctrl_reg <= '0;
      skid_ctrl_reg <= '0;
      if (FLUSH_KEEP_DATA != 0) begin
        main_data_reg <= in_data;
      end
      kill_reg <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_data_reg <= in_data;
            main_ctrl_reg <= in_ctrl;
            state_reg     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_data_reg <= in_data;
            skid_ctrl_reg <= in_ctrl;
            state_reg     <= FULL;
          end else if (in_fire && out_fire) begin
            main_data_reg <= in_data;
            main_ctrl_reg <= in_ctrl;
          end else if (out_fire) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data_reg <= skid_data_reg;
            main_ctrl_reg <= skid_ctrl_reg;
            state_reg     <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, flush, kill_cnt saturation, async reset.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 10;

  logic              clk = 1'b1;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [15:0]       kill_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_KEEP_DATA(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .kill_cnt(kill_cnt)
  );

  always #5 clk = ~clk;

  // DUT updates on negedge; the bench drives and samples around the posedge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
    $display("check %-16s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_occ", occupancy, 0);
    check("rst_kill", kill_cnt, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_data", out_data, 0);
    @(posedge clk);
    rst = 1'b1;

    // Streaming: each entry appears one edge later, occupancy stays 1
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i * 16 + 3));
      tick();
      check("stream_ctrl", out_ctrl, i);
      check("stream_occ", occupancy, 1);
      check("stream_ready", in_ready, 1);
    end
    check("stream_data", out_data, 8 * 16 + 3);
    drive(1'b0, '0, '0);
    tick();
    check("drain_occ", occupancy, 0);
    check("drain_ctrl", out_ctrl, 0);
    check("drain_valid", out_valid, 0);

    // Backpressure: A, B held, C ignored, then A/B emerge in order
    out_ready = 1'b0;
    drive(1'b1, 10'h011, 101'hA);
    tick();
    check("bp_occ1", occupancy, 1);
    check("bp_ctrlA", out_ctrl, 10'h011);
    drive(1'b1, 10'h022, 101'hB);
    tick();
    check("bp_occ2", occupancy, 2);
    check("bp_ready0", in_ready, 0);
    drive(1'b1, 10'h033, 101'hC);
    tick();
    check("bp_holdC", out_ctrl, 10'h011);
    check("bp_holdocc", occupancy, 2);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    check("bp_ctrlB", out_ctrl, 10'h022);
    check("bp_dataB", out_data, 101'hB);
    check("bp_occ1b", occupancy, 1);
    tick();
    check("bp_occ0", occupancy, 0);

    // Flush in FULL with no input: +2, main data captures flush-cycle in_data
    out_ready = 1'b0;
    drive(1'b1, 10'h005, 101'h5);
    tick();
    drive(1'b1, 10'h006, 101'h6);
    tick();
    check("fl_full_occ", occupancy, 2);
    flush = 1'b1;
    drive(1'b0, 10'h3FF, 101'hDEAD);
    tick();
    flush = 1'b0;
    check("fl_full_valid", out_valid, 0);
    check("fl_full_ctrl", out_ctrl, 0);
    check("fl_full_kill", kill_cnt, 2);
    check("fl_full_data", out_data, 101'hDEAD);
    check("fl_full_occ0", occupancy, 0);

    // Flush in ONE with an incoming entry (and an output transfer): +2
    drive(1'b1, 10'h007, 101'h7);
    tick();
    check("fl_one_occ", occupancy, 1);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 10'h008, 101'h8);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("fl_one_kill", kill_cnt, 4);
    check("fl_one_occ0", occupancy, 0);

    // Drive kill_cnt to 0xFFFE, two entries at a time
    for (int i = 0; i < 32765; i++) begin
      flush = 1'b0;
      drive(1'b1, 10'h001, 101'h1);
      tick();
      flush = 1'b1;
      tick();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("sat_pre", kill_cnt, 16'hFFFE);
    drive(1'b1, 10'h00A, 101'hA);
    tick();
    drive(1'b1, 10'h00B, 101'hB);
    tick();
    check("sat_full_occ", occupancy, 2);
    flush = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    check("sat_kill", kill_cnt, 16'hFFFF);
    drive(1'b1, 10'h00C, 101'hC);
    tick();
    flush = 1'b0;
    check("sat_hold", kill_cnt, 16'hFFFF);

    // Reset mid-stream in FULL: outputs clear without a clock edge
    drive(1'b1, 10'h00D, 101'hD);
    tick();
    drive(1'b1, 10'h00E, 101'hE);
    tick();
    check("rf_occ2", occupancy, 2);
    drive(1'b0, '0, '0);
    #2;
    rst = 1'b0;
    #1;
    check("rf_valid", out_valid, 0);
    check("rf_data", out_data, 0);
    check("rf_ctrl", out_ctrl, 0);
    check("rf_occ", occupancy, 0);
    check("rf_kill", kill_cnt, 0);
    check("rf_ready", in_ready, 1);
    @(posedge clk);
    rst = 1'b1;
    drive(1'b1, 10'h077, 101'h77);
    tick();
    check("rf_first_occ", occupancy, 1);
    check("rf_first_ctrl", out_ctrl, 10'h077);
    check("rf_first_kill", kill_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
